// File: rtl/aes_key_scheduler_pkg.sv
// aes_pkg: shared AES constants, state type and byte/word helpers for the key schedule
// Provides RK_W (round-key width), RCON_INIT, state_t, xtime, sbox, rot_word, sub_word.
// Words are little-endian in bytes: byte 0 of a word sits in bits [7:0].
package aes_pkg;
  localparam int RK_W = 128;
  localparam logic [7:0] RCON_INIT = 8'h01;
  typedef enum logic {IDLE, RUN} state_t;
  // S-box entry 0 occupies the top byte, so entry x lives at bit offset 8*(255-x).
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  // 255-x is ~x for a byte, giving the offset without arithmetic.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[7:0], w[31:8]};
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
endpackage

// File: rtl/aes_key_scheduler_if.sv
// aes_key_scheduler_if: control and round-key stream bundle of the key scheduler
// master (scheduler side): in start, key_in, rk_ready; out busy, rk_valid, rk_data, rk_idx, done.
// slave (round-engine/controller side): the mirror image.
interface aes_key_scheduler_if #(parameter int NK = 4) ();
  import aes_pkg::*;
  logic start;
  logic [32*NK-1:0] key_in;
  logic busy;
  logic rk_valid;
  logic rk_ready;
  logic [RK_W-1:0] rk_data;
  logic [3:0] rk_idx;
  logic done;
  modport master (input start, key_in, rk_ready, output busy, rk_valid, rk_data, rk_idx, done);
  modport slave (output start, key_in, rk_ready, input busy, rk_valid, rk_data, rk_idx, done);
endinterface

// File: rtl/aes_key_step.sv
// aes_key_step: one combinational key-expansion step over an NK-word window
// Ports: win_i current window (word 0 in [31:0]), rc_i round constant, win_o next window.
module aes_key_step import aes_pkg::*; #(parameter int NK = 4) (
  input  logic [32*NK-1:0] win_i,
  input  logic [7:0]       rc_i,
  output logic [32*NK-1:0] win_o
);
  for (genvar i = 0; i < NK; i++) begin : g_w
    logic [31:0] n;
    if (i == 0) begin : g_first
      assign n = win_i[31:0] ^ sub_word(rot_word(win_i[32*NK-1 -: 32])) ^ {24'h0, rc_i};
    end else if (NK == 8 && i == 4) begin : g_mid
      // AES-256 inserts an extra SubWord halfway through the window.
      assign n = win_i[159:128] ^ sub_word(g_w[3].n);
    end else begin : g_chain
      assign n = g_w[i-1].n ^ win_i[32*i +: 32];
    end
    assign win_o[32*i +: 32] = n;
  end
endmodule

// File: rtl/aes_key_scheduler.sv
// aes_key_scheduler: sequential AES key schedule streaming round keys 0..NR over valid/ready
// Ports: clk, rst_n (async active-low); bus.master: start/key_in in, busy out,
// rk_valid/rk_data/rk_idx out with rk_ready in, done one-cycle pulse after key NR is taken.
module aes_key_scheduler import aes_pkg::*; #(parameter int NK = 4) (
  input logic clk,
  input logic rst_n,
  aes_key_scheduler_if.master bus
);
  localparam logic [3:0] NR = NK == 4 ? 4'd10 : 4'd14;
  if (NK != 4 && NK != 8) begin : g_nk_check
    $error("aes_key_scheduler: NK must be 4 or 8");
  end
  state_t state_q, state_d;
  logic [32*NK-1:0] win_q, win_d, win_step;
  logic [7:0] rc_q, rc_d;
  logic half_q, half_d, done_q, done_d;
  logic [3:0] idx_q, idx_d;
  aes_key_step #(.NK(NK)) u_step (.win_i(win_q), .rc_i(rc_q), .win_o(win_step));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q <= '0;
      rc_q <= RCON_INIT;
      half_q <= 1'b0;
      idx_q <= 4'd0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      rc_q <= rc_d;
      half_q <= half_d;
      idx_q <= idx_d;
      done_q <= done_d;
    end
  end
  // For NK=8 each window yields two round keys; the window only advances after its upper half.
  always_comb begin
    state_d = state_q;
    win_d = win_q;
    rc_d = rc_q;
    half_d = half_q;
    idx_d = idx_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (bus.start) begin
        state_d = RUN;
        win_d = bus.key_in;
        rc_d = RCON_INIT;
        half_d = 1'b0;
        idx_d = 4'd0;
      end
    end else if (bus.rk_ready) begin
      if (idx_q == NR) begin
        state_d = IDLE;
        done_d = 1'b1;
      end else begin
        idx_d = idx_q + 4'd1;
        half_d = NK == 8 && !half_q;
        if (NK == 4 || half_q) begin
          win_d = win_step;
          rc_d = xtime(rc_q);
        end
      end
    end
  end
  assign bus.busy = state_q == RUN;
  assign bus.rk_valid = state_q == RUN;
  assign bus.rk_data = half_q ? win_q[32*NK-1 -: RK_W] : win_q[RK_W-1:0];
  assign bus.rk_idx = idx_q;
  assign bus.done = done_q;
endmodule
